pipeline_sequencer: RTL and testbench

Central sequencer for the 5-stage MIPS pipeline. It owns the global run/step/halt state machine and per-stage register enables, and detects load-use hazards. It drives the Control unit's i_control_mux to insert bubbles and flushes IF/ID on taken branches/jumps. It sits beside Control and the hazard/forwarding logic and is the only source of pipeline enables.

---
 rtl/pipeline_sequencer_pkg.sv | 17 +
 rtl/pipeline_sequencer_hazard.sv | 17 +
 rtl/pipeline_sequencer.sv | 128 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings and parameter defaults.
package pipeline_sequencer_pkg;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF        = 32;
  localparam int REG_W_DEF        = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    DRAIN     = 3'd4,
    HALTED    = 3'd5
  } state_t;

endpackage

// File: rtl/pipeline_sequencer_hazard.sv
// Load-use hazard detection: a load in EX whose destination feeds the instruction in ID.
module pipeline_sequencer_hazard #(
  parameter int REG_W = 5
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             uses_rt,
  output logic             load_use
);

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline; sole source of stage enables and bubbles.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int REG_W        = REG_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mode_step,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_halt_fetched,
  input  logic             i_restart,
  input  logic             i_id_ex_MemRead,
  input  logic [REG_W-1:0] i_id_ex_rt,
  input  logic [REG_W-1:0] i_if_id_rs,
  input  logic [REG_W-1:0] i_if_id_rt,
  input  logic             i_if_id_uses_rt,
  input  logic             i_branch_taken,
  output logic             o_pc_enable,
  output logic             o_if_id_enable,
  output logic             o_pipe_enable,
  output logic             o_control_mux,
  output logic             o_if_id_flush,
  output logic             o_halted,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               step_prev;
  logic [CNT_W-1:0]   cycle_count;
  logic               load_use;
  logic               active;
  logic               step_edge;
  logic               halt_take;

  pipeline_sequencer_hazard #(.REG_W(REG_W)) u_hazard (
    .mem_read (i_id_ex_MemRead),
    .ex_rt    (i_id_ex_rt),
    .id_rs    (i_if_id_rs),
    .id_rt    (i_if_id_rt),
    .uses_rt  (i_if_id_uses_rt),
    .load_use (load_use)
  );

  assign active    = (state == RUN) || (state == STEP_EXEC);
  assign step_edge = i_step && !step_prev;
  // A stalled cycle does not advance PC, so the HALT is seen again next cycle.
  assign halt_take = active && !load_use && i_halt_fetched;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    o_pc_enable    = 1'b0;
    o_if_id_enable = 1'b0;
    o_pipe_enable  = 1'b0;
    o_control_mux  = 1'b0;
    o_if_id_flush  = 1'b0;
    if (active) begin
      o_pipe_enable = 1'b1;
      if (!load_use) begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
        o_control_mux  = 1'b1;
        o_if_id_flush  = i_branch_taken;
      end
    end else if (state == DRAIN) begin
      o_pipe_enable = 1'b1;
    end
  end

  assign o_halted      = (state == HALTED);
  assign o_state       = state;
  assign o_cycle_count = cycle_count;

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      step_prev   <= 1'b0;
      cycle_count <= '0;
    end else begin
      step_prev <= i_step;
      if (o_pipe_enable) cycle_count <= cycle_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (i_mode_step)  state <= STEP_WAIT;
          else if (i_start) state <= RUN;
        end
        RUN: begin
          if (halt_take) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
          end
        end
        STEP_WAIT: begin
          if (step_edge) state <= STEP_EXEC;
        end
        STEP_EXEC: begin
          if (halt_take) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
          end else begin
            state <= STEP_WAIT;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= HALTED;
          else                 drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
        HALTED: begin
          if (i_restart) begin
            state       <= IDLE;
            cycle_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: hazard/flush vector table plus run, step, drain and reset sequences.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_step, start, step, halt_fetched, restart;
  logic        mem_read, uses_rt, branch_taken;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        pc_en, ifid_en, pipe_en, ctl_mux, ifid_flush, halted;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  int vectors_applied = 0;
  int miscompares     = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_mode_step     (mode_step),
    .i_start         (start),
    .i_step          (step),
    .i_halt_fetched  (halt_fetched),
    .i_restart       (restart),
    .i_id_ex_MemRead (mem_read),
    .i_id_ex_rt      (ex_rt),
    .i_if_id_rs      (id_rs),
    .i_if_id_rt      (id_rt),
    .i_if_id_uses_rt (uses_rt),
    .i_branch_taken  (branch_taken),
    .o_pc_enable     (pc_en),
    .o_if_id_enable  (ifid_en),
    .o_pipe_enable   (pipe_en),
    .o_control_mux   (ctl_mux),
    .o_if_id_flush   (ifid_flush),
    .o_halted        (halted),
    .o_state         (state),
    .o_cycle_count   (cycle_count)
  );

  typedef struct {
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic [4:0] exp; // {pc, if_id, control_mux, flush, pipe}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {pc_en, ifid_en, ctl_mux, ifid_flush, pipe_en};
  endfunction

  task automatic clear_hazard();
    mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; uses_rt = 0; branch_taken = 0;
  endtask

  initial begin
    vecs[0] = '{0, 5'd0,  5'd0,  5'd0,  0, 0, 5'b11101};
    vecs[1] = '{1, 5'd5,  5'd5,  5'd0,  0, 0, 5'b00001};
    vecs[2] = '{1, 5'd0,  5'd0,  5'd0,  1, 0, 5'b11101};
    vecs[3] = '{1, 5'd5,  5'd3,  5'd5,  1, 0, 5'b00001};
    vecs[4] = '{1, 5'd5,  5'd3,  5'd5,  0, 0, 5'b11101};
    vecs[5] = '{0, 5'd5,  5'd5,  5'd5,  1, 0, 5'b11101};
    vecs[6] = '{0, 5'd0,  5'd0,  5'd0,  0, 1, 5'b11111};
    vecs[7] = '{1, 5'd5,  5'd5,  5'd0,  0, 1, 5'b00001};
    vecs[8] = '{1, 5'd31, 5'd1,  5'd31, 1, 0, 5'b00001};
    vecs[9] = '{1, 5'd31, 5'd30, 5'd30, 1, 1, 5'b11111};

    rst_n = 0; mode_step = 0; start = 0; step = 0; halt_fetched = 0; restart = 0;
    clear_hazard();
    #12;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_outs", {27'd0, outs()}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_count", cycle_count, 32'd0);
    rst_n = 1;
    tick();
    check("idle_hold", {29'd0, state}, 32'd0);

    // Free-run start
    start = 1;
    tick();
    start = 0;
    check("run_state", {29'd0, state}, 32'd1);
    check("run_outs", {27'd0, outs()}, {27'd0, 5'b11101});
    check("run_count0", cycle_count, 32'd0);
    repeat (10) tick();
    check("run_count10", cycle_count, 32'd10);

    // Hazard / flush vector table
    for (int i = 0; i < 10; i++) begin
      mem_read = vecs[i].mem_read; ex_rt = vecs[i].ex_rt; id_rs = vecs[i].rs;
      id_rt = vecs[i].rt; uses_rt = vecs[i].uses_rt; branch_taken = vecs[i].branch;
      #1;
      check($sformatf("vec%0d", i), {27'd0, outs()}, {27'd0, vecs[i].exp});
      tick();
    end
    clear_hazard();
    check("run_count20", cycle_count, 32'd20);

    // HALT during a stall is ignored; next unstalled cycle enters DRAIN
    mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9; halt_fetched = 1;
    tick();
    check("halt_stalled", {29'd0, state}, 32'd1);
    mem_read = 0;
    tick();
    halt_fetched = 0;
    check("drain_enter", {29'd0, state}, 32'd4);
    check("drain_count", cycle_count, 32'd22);
    branch_taken = 1; mem_read = 0;
    #1;
    check("drain_outs", {27'd0, outs()}, {27'd0, 5'b00001});
    branch_taken = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("drain_hold%0d", i), {29'd0, state}, 32'd4);
    end
    tick();
    check("halted_state", {29'd0, state}, 32'd5);
    check("halted_flag", {31'd0, halted}, 32'd1);
    check("halted_count", cycle_count, 32'd26);
    check("halted_outs", {27'd0, outs()}, 32'd0);
    start = 1; step = 1;
    repeat (3) tick();
    check("halted_ignore", {29'd0, state}, 32'd5);
    check("halted_frozen", cycle_count, 32'd26);
    start = 0; step = 0;
    restart = 1;
    tick();
    restart = 0;
    check("restart_state", {29'd0, state}, 32'd0);
    check("restart_count", cycle_count, 32'd0);

    // Step mode: held level counts once
    mode_step = 1;
    tick();
    check("step_wait", {29'd0, state}, 32'd2);
    check("step_wait_outs", {27'd0, outs()}, 32'd0);
    step = 1;
    tick();
    check("step_exec", {29'd0, state}, 32'd3);
    check("step_exec_outs", {27'd0, outs()}, {27'd0, 5'b11101});
    repeat (4) tick();
    check("step_held", cycle_count, 32'd1);
    check("step_held_state", {29'd0, state}, 32'd2);
    step = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      step = 1; tick();
      step = 0; tick();
      tick();
    end
    check("step_pulses", cycle_count, 32'd4);

    // HALT in a step cycle, then async reset in DRAIN
    step = 1; tick();
    step = 0; halt_fetched = 1;
    tick();
    halt_fetched = 0;
    check("step_drain", {29'd0, state}, 32'd4);
    tick();
    check("step_drain_count", cycle_count, 32'd6);
    #2;
    rst_n = 0;
    #1;
    check("async_state", {29'd0, state}, 32'd0);
    check("async_outs", {27'd0, outs()}, 32'd0);
    check("async_count", cycle_count, 32'd0);
    rst_n = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
